// File: rtl/junction_controller.sv
// Demand-driven two-road junction sequencer with pedestrian phase insertion
// and fault flashing; all timing counts ticks of an external timebase enable.
module junction_controller #(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 12,
  parameter int AMBER_T    = 2,
  parameter int REDAMBER_T = 1,
  parameter int ALLRED_T   = 1,
  parameter int WALK_T     = 6,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sensA,
  input  logic       sensB,
  input  logic       ped_req,
  input  logic       fault,
  output logic [2:0] lightsA,
  output logic [2:0] lightsB,
  output logic       ped_walk,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    ALLRED_A = 4'd0,
    RA_A     = 4'd1,
    GREEN_A  = 4'd2,
    AMBER_A  = 4'd3,
    ALLRED_B = 4'd4,
    RA_B     = 4'd5,
    GREEN_B  = 4'd6,
    AMBER_B  = 4'd7,
    PED      = 4'd8,
    FLASH    = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] RA_END     = CNT_W'(REDAMBER_T - 1);
  localparam logic [CNT_W-1:0] AMBER_END  = CNT_W'(AMBER_T - 1);
  localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ped_pending;
  logic             last_road;
  logic             flash;

  logic             green_done_a;
  logic             green_done_b;
  logic [CNT_W-1:0] green_cnt;

  // A green yields early only when its own road is empty; at max green it
  // yields to any waiting demand. With no demand it rests indefinitely.
  assign green_done_a = (sensB | ped_pending) &&
                        ((cnt >= GMIN_END && !sensA) || cnt >= GMAX_END);
  assign green_done_b = (sensA | ped_pending) &&
                        ((cnt >= GMIN_END && !sensB) || cnt >= GMAX_END);
  assign green_cnt    = (cnt >= GMAX_END) ? GMAX_END : cnt + CNT_ONE;

  // Fault entry/exit ignores tick; everything else advances only on tick.
  // The PED-entry clear of ped_pending is written last so it wins over a
  // same-cycle button press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ALLRED_A;
      cnt         <= '0;
      ped_pending <= 1'b0;
      last_road   <= 1'b1;
      flash       <= 1'b0;
    end else begin
      if (ped_req)
        ped_pending <= 1'b1;
      if (fault) begin
        if (state != FLASH) begin
          state <= FLASH;
          cnt   <= '0;
        end else if (tick) begin
          flash <= ~flash;
        end
      end else if (state == FLASH) begin
        state <= ALLRED_A;
        cnt   <= '0;
        flash <= 1'b0;
      end else if (tick) begin
        cnt <= cnt + CNT_ONE;
        case (state)
          ALLRED_A: if (cnt == ALLRED_END) begin
            state <= RA_A;
            cnt   <= '0;
          end
          RA_A: if (cnt == RA_END) begin
            state     <= GREEN_A;
            cnt       <= '0;
            last_road <= 1'b0;
          end
          GREEN_A: if (green_done_a) begin
            state <= AMBER_A;
            cnt   <= '0;
          end else begin
            cnt <= green_cnt;
          end
          AMBER_A: if (cnt == AMBER_END) begin
            cnt <= '0;
            if (ped_pending) begin
              state       <= PED;
              ped_pending <= 1'b0;
            end else begin
              state <= ALLRED_B;
            end
          end
          ALLRED_B: if (cnt == ALLRED_END) begin
            state <= RA_B;
            cnt   <= '0;
          end
          RA_B: if (cnt == RA_END) begin
            state     <= GREEN_B;
            cnt       <= '0;
            last_road <= 1'b1;
          end
          GREEN_B: if (green_done_b) begin
            state <= AMBER_B;
            cnt   <= '0;
          end else begin
            cnt <= green_cnt;
          end
          AMBER_B: if (cnt == AMBER_END) begin
            cnt <= '0;
            if (ped_pending) begin
              state       <= PED;
              ped_pending <= 1'b0;
            end else begin
              state <= ALLRED_A;
            end
          end
          PED: if (cnt == WALK_END) begin
            cnt   <= '0;
            state <= last_road ? ALLRED_A : ALLRED_B;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    lightsA  = 3'b100;
    lightsB  = 3'b100;
    ped_walk = 1'b0;
    case (state)
      RA_A:    lightsA = 3'b110;
      GREEN_A: lightsA = 3'b001;
      AMBER_A: lightsA = 3'b010;
      RA_B:    lightsB = 3'b110;
      GREEN_B: lightsB = 3'b001;
      AMBER_B: lightsB = 3'b010;
      PED:     ped_walk = 1'b1;
      FLASH: begin
        lightsA = {1'b0, flash, 1'b0};
        lightsB = {1'b0, flash, 1'b0};
      end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_junction_controller.sv
// Directed, table-driven bench for junction_controller: each record holds
// inputs, a hold length in cycles and the hand-computed phase/lights/walk.
module tb_junction_controller;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       sensA;
  logic       sensB;
  logic       ped_req;
  logic       fault;
  logic [2:0] lightsA;
  logic [2:0] lightsB;
  logic       ped_walk;
  logic [3:0] phase;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    bit         rstBefore;
    logic       tick;
    logic       sensA;
    logic       sensB;
    logic       pedReq;
    logic       fault;
    int         cycles;
    logic [3:0] expPhase;
    logic [2:0] expA;
    logic [2:0] expB;
    logic       expWalk;
  } vec_t;

  vec_t vecs[$];

  junction_controller dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .sensA   (sensA),
    .sensB   (sensB),
    .ped_req (ped_req),
    .fault   (fault),
    .lightsA (lightsA),
    .lightsB (lightsB),
    .ped_walk(ped_walk),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVector(input bit r, input logic t, input logic sa, input logic sb,
                           input logic pr, input logic f, input int n, input logic [3:0] ph,
                           input logic [2:0] a, input logic [2:0] b, input logic w);
    vec_t v;
    v.rstBefore = r; v.tick = t; v.sensA = sa; v.sensB = sb; v.pedReq = pr; v.fault = f;
    v.cycles = n; v.expPhase = ph; v.expA = a; v.expB = b; v.expWalk = w;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ph, input logic [2:0] a,
                             input logic [2:0] b, input logic w);
    checkCount++;
    if (phase !== ph || lightsA !== a || lightsB !== b || ped_walk !== w) begin
      errorCount++;
      $display("[TB] FAIL %s: got phase=%0d A=%b B=%b walk=%b, expected phase=%0d A=%b B=%b walk=%b",
               name, phase, lightsA, lightsB, ped_walk, ph, a, b, w);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic sa, input logic sb,
                               input logic pr, input logic f);
    tick = t; sensA = sa; sensB = sb; ped_req = pr; fault = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkOutput(name, 4'd0, 3'b100, 3'b100, 1'b0);
  endtask

  int endCyc[6] = '{2, 5, 17, 23, 26, 29};

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Scenario 1: B waiting, A empty; B rests until A demand arrives.
    addVector(1, 1,0,1,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  4, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  2, 4'd3, 3'b010, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  1, 4'd4, 3'b100, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  1, 4'd5, 3'b100, 3'b110, 0);
    addVector(0, 1,0,1,0,0, 15, 4'd6, 3'b100, 3'b001, 0);
    addVector(0, 1,1,0,0,0,  2, 4'd7, 3'b100, 3'b010, 0);
    addVector(0, 1,1,0,0,0,  1, 4'd0, 3'b100, 3'b100, 0);
    addVector(0, 1,1,0,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,1,0,0,0,  5, 4'd2, 3'b001, 3'b100, 0);
    // Scenario 2: no traffic at all, A green rests.
    addVector(1, 1,0,0,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,0,0,0,0, 50, 4'd2, 3'b001, 3'b100, 0);
    // Scenario 3: both roads busy, max green alternation.
    addVector(1, 1,1,1,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,1,1,0,0, 12, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,1,1,0,0,  2, 4'd3, 3'b010, 3'b100, 0);
    addVector(0, 1,1,1,0,0,  1, 4'd4, 3'b100, 3'b100, 0);
    addVector(0, 1,1,1,0,0,  1, 4'd5, 3'b100, 3'b110, 0);
    addVector(0, 1,1,1,0,0, 12, 4'd6, 3'b100, 3'b001, 0);
    addVector(0, 1,1,1,0,0,  2, 4'd7, 3'b100, 3'b010, 0);
    addVector(0, 1,1,1,0,0,  1, 4'd0, 3'b100, 3'b100, 0);
    addVector(0, 1,1,1,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,1,1,0,0,  3, 4'd2, 3'b001, 3'b100, 0);
    // Scenario 4: pedestrian pulse during A green.
    addVector(1, 1,0,0,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,0,0,0,0,  1, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,0,0,1,0,  1, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,0,0,0,0,  2, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,0,0,0,0,  2, 4'd3, 3'b010, 3'b100, 0);
    addVector(0, 1,0,0,0,0,  6, 4'd8, 3'b100, 3'b100, 1);
    addVector(0, 1,0,0,0,0,  1, 4'd4, 3'b100, 3'b100, 0);
    addVector(0, 1,0,0,0,0,  1, 4'd5, 3'b100, 3'b110, 0);
    addVector(0, 1,0,0,0,0,  3, 4'd6, 3'b100, 3'b001, 0);
    // Scenario 5: ped latched, then fault in B green; flash, recover, ped served.
    addVector(1, 1,0,1,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  4, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  2, 4'd3, 3'b010, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  1, 4'd4, 3'b100, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  1, 4'd5, 3'b100, 3'b110, 0);
    addVector(0, 1,0,1,0,0,  2, 4'd6, 3'b100, 3'b001, 0);
    addVector(0, 1,0,1,1,0,  1, 4'd6, 3'b100, 3'b001, 0);
    addVector(0, 1,0,1,0,1,  1, 4'd9, 3'b000, 3'b000, 0);
    addVector(0, 1,0,1,0,1,  1, 4'd9, 3'b010, 3'b010, 0);
    addVector(0, 1,0,1,0,1,  1, 4'd9, 3'b000, 3'b000, 0);
    addVector(0, 1,0,1,0,1,  1, 4'd9, 3'b010, 3'b010, 0);
    addVector(0, 0,0,1,0,1,  2, 4'd9, 3'b010, 3'b010, 0);
    addVector(0, 0,0,1,0,0,  1, 4'd0, 3'b100, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  1, 4'd1, 3'b110, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  4, 4'd2, 3'b001, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  2, 4'd3, 3'b010, 3'b100, 0);
    addVector(0, 1,0,1,0,0,  6, 4'd8, 3'b100, 3'b100, 1);
    addVector(0, 1,0,1,0,0,  1, 4'd4, 3'b100, 3'b100, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rstBefore)
        resetDut($sformatf("reset_before_vec%0d", i));
      applyStimulus(vecs[i].tick, vecs[i].sensA, vecs[i].sensB, vecs[i].pedReq, vecs[i].fault);
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        checkOutput($sformatf("vec%0d_cyc%0d", i, c), vecs[i].expPhase,
                    vecs[i].expA, vecs[i].expB, vecs[i].expWalk);
        if (vecs[i].pedReq)
          ped_req = 1'b0;
      end
    end

    // Scenario 6: tick every third cycle stretches every duration by 3.
    resetDut("reset_scaled");
    for (int cyc = 1; cyc <= 32; cyc++) begin
      logic [3:0] expPh;
      logic [2:0] ea;
      logic [2:0] eb;
      applyStimulus((cyc % 3) == 0, 1'b0, 1'b1, 1'b0, 1'b0);
      expPh = 4'd6;
      for (int k = 5; k >= 0; k--)
        if (cyc <= endCyc[k]) expPh = 4'(k);
      case (expPh)
        4'd1:    begin ea = 3'b110; eb = 3'b100; end
        4'd2:    begin ea = 3'b001; eb = 3'b100; end
        4'd3:    begin ea = 3'b010; eb = 3'b100; end
        4'd5:    begin ea = 3'b100; eb = 3'b110; end
        4'd6:    begin ea = 3'b100; eb = 3'b001; end
        default: begin ea = 3'b100; eb = 3'b100; end
      endcase
      step();
      checkOutput($sformatf("scaled_cyc%0d", cyc), expPh, ea, eb, 1'b0);
    end

    // Drive B out of green, then pull reset asynchronously mid-AMBER_B.
    begin
      int waited = 0;
      int cyc = 33;
      while (phase != 4'd7 && waited < 200) begin
        applyStimulus((cyc % 3) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        cyc++;
        waited++;
      end
      checkCount++;
      if (phase != 4'd7) begin
        errorCount++;
        $display("[TB] FAIL reach_amber_b: got phase=%0d, expected phase=7 within 200 cycles", phase);
      end else begin
        applyStimulus((cyc % 3) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("amber_b_held", 4'd7, 3'b100, 3'b010, 1'b0);
      end
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 4'd0, 3'b100, 3'b100, 1'b0);
      step();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
